// File: rtl/fetch_dispatch_ctrl.sv
// Fetch/dispatch controller: fetches 16-bit instructions from a registered ROM into the
// instruction register and hands them to execute FSMs until done, halt or timeout.
module fetch_dispatch_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [15:0]       memData,
  input  logic              pcInc,
  input  logic              done,
  output logic [15:0]       instruction,
  output logic              irValid,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [CNT_W-1:0]  cnt_q;

  // Handshake: pcInc and done are single-cycle strobes from the execute FSMs and are only
  // sampled while irValid is high; the IR stays stable until the cycle after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ir_q <= '0;
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          if (memData[15:12] == OP_HALT) begin
            ir_q    <= '0;
            state_q <= S_HALT;
          end else if (memData[15:12] == OP_NOP) begin
            ir_q    <= memData;
            pc_q    <= pc_q + PC_ONE;
            state_q <= run ? S_FETCH : S_IDLE;
          end else begin
            ir_q    <= memData;
            cnt_q   <= CNT_ONE;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (pcInc) pc_q <= pc_q + PC_ONE;
          if (done) begin
            ir_q    <= '0;
            cnt_q   <= '0;
            state_q <= run ? S_FETCH : S_IDLE;
          end else if (cnt_q == CNT_MAX) begin
            ir_q    <= '0;
            state_q <= S_FAULT;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_HALT, S_FAULT: ir_q <= '0;
        default: begin
          ir_q    <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign memAddr     = pc_q;
  assign instruction = ir_q;
  assign irValid     = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// Directed bench for fetch_dispatch_ctrl with a registered ROM model and hand-computed
// expectations for each scenario.
module tb_fetch_dispatch_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        pc_inc;
  logic        done;
  logic [15:0] instruction;
  logic        ir_valid;
  logic        halted;
  logic        fault;
  logic [2:0]  state_dbg;

  logic [15:0] rom [256];

  int checks = 0;
  int failures = 0;

  fetch_dispatch_ctrl #(.ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .memAddr(mem_addr), .memData(mem_data),
    .pcInc(pc_inc), .done(done), .instruction(instruction), .irValid(ir_valid),
    .halted(halted), .fault(fault), .state_dbg(state_dbg)
  );

  // clock / reset / ROM
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) mem_data <= rom[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; pc_inc = 1'b0; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // From IDLE with run high: FETCH, LATCH, then first EXEC cycle.
  task automatic go_to_exec();
    run = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; pc_inc = 1'b0; done = 1'b0;
    clear_rom();

    // Reset state
    do_reset();
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_pc", 32'(mem_addr), 32'h0);
    check("rst_ir", 32'(instruction), 32'h0);
    check("rst_flags", 32'({ir_valid, halted, fault}), 32'h0);
    tick(); tick();
    check("idle_hold", 32'(state_dbg), 32'(S_IDLE));

    // MOVi: pcInc on EXEC cycle 2, done on cycle 4
    rom[0] = 16'h5045; rom[1] = 16'hF000;
    go_to_exec();
    n = 0;
    for (int c = 1; c <= 4; c++) begin
      if (ir_valid && instruction == 16'h5045) n++;
      pc_inc = (c == 2);
      done   = (c == 4);
      tick();
    end
    pc_inc = 1'b0; done = 1'b0;
    check("movi_exec_cycles", 32'(n), 32'd4);
    check("movi_ir_clear", 32'(instruction), 32'h0);
    check("movi_pc", 32'(mem_addr), 32'h1);
    check("movi_fetch", 32'(state_dbg), 32'(S_FETCH));
    tick(); tick();
    check("movi_halt", 32'({halted, ir_valid, fault}), 32'b100);
    check("movi_halt_ir", 32'(instruction), 32'h0);
    run = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("halt_pc_frozen", 32'(mem_addr), 32'h1);
    check("halt_terminal", 32'(state_dbg), 32'(S_HALT));

    // NOP then HALT
    clear_rom(); rom[1] = 16'hF000;
    do_reset();
    run = 1'b1;
    tick(); tick(); tick();
    check("nop_pc", 32'(mem_addr), 32'h1);
    check("nop_no_exec", 32'(state_dbg), 32'(S_FETCH));
    tick(); tick();
    check("nop_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 10; i++) tick();
    check("nop_halt_pc", 32'(mem_addr), 32'h1);

    // Timeout fault
    clear_rom(); rom[0] = 16'h5000;
    do_reset();
    go_to_exec();
    n = 0;
    while (ir_valid && n < 40) begin
      n++;
      tick();
    end
    check("to_cycles", 32'(n), 32'd15);
    check("to_fault", 32'({fault, halted, ir_valid}), 32'b100);
    check("to_ir", 32'(instruction), 32'h0);
    pc_inc = 1'b1; done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pc_inc = 1'b0; done = 1'b0;
    check("to_fault_hold", 32'(state_dbg), 32'(S_FAULT));
    check("to_pc_frozen", 32'(mem_addr), 32'h0);

    // PC wrap through a NOP stream
    clear_rom();
    do_reset();
    run = 1'b1;
    n = 0;
    while (mem_addr != 8'hFF && n < 600) begin
      n++;
      tick();
    end
    check("wrap_reach_ff", 32'(mem_addr), 32'hFF);
    tick(); tick();
    check("wrap_pc0", 32'(mem_addr), 32'h0);
    check("wrap_fetch", 32'(state_dbg), 32'(S_FETCH));
    tick(); tick();
    check("wrap_continue", 32'(mem_addr), 32'h1);

    // run dropped on EXEC cycle 2, done on cycle 4
    clear_rom(); rom[0] = 16'h5045; rom[1] = 16'h6001;
    do_reset();
    go_to_exec();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) run = 1'b0;
      pc_inc = (c == 2);
      done   = (c == 4);
      tick();
    end
    pc_inc = 1'b0; done = 1'b0;
    check("rundrop_idle", 32'(state_dbg), 32'(S_IDLE));
    check("rundrop_ir", 32'(instruction), 32'h0);
    pc_inc = 1'b1; done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pc_inc = 1'b0; done = 1'b0;
    check("idle_ignores_strobes", 32'(mem_addr), 32'h1);
    check("rundrop_stay_idle", 32'(state_dbg), 32'(S_IDLE));
    run = 1'b1;
    tick();
    check("resume_fetch", 32'({state_dbg, mem_addr}), 32'({S_FETCH, 8'h01}));
    tick(); tick();
    check("resume_ir", 32'(instruction), 32'h6001);

    // pcInc and done together in one EXEC cycle
    clear_rom(); rom[0] = 16'h7123; rom[1] = 16'hF000;
    do_reset();
    go_to_exec();
    pc_inc = 1'b1; done = 1'b1;
    tick();
    pc_inc = 1'b0; done = 1'b0;
    check("both_pc", 32'(mem_addr), 32'h1);
    check("both_fetch", 32'(state_dbg), 32'(S_FETCH));

    // Async reset mid-EXEC with pending pcInc
    clear_rom(); rom[0] = 16'h5045;
    do_reset();
    go_to_exec();
    tick(); tick();
    pc_inc = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state_dbg), 32'(S_IDLE));
    check("arst_pc", 32'(mem_addr), 32'h0);
    check("arst_ir", 32'(instruction), 32'h0);
    check("arst_flags", 32'({ir_valid, halted, fault}), 32'h0);
    tick();
    rst = 1'b0; pc_inc = 1'b0; run = 1'b0;
    tick(); tick();
    check("arst_idle_wait", 32'(state_dbg), 32'(S_IDLE));
    run = 1'b1;
    tick();
    check("arst_refetch", 32'({state_dbg, mem_addr}), 32'({S_FETCH, 8'h00}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
